// File: rtl/enigma_pkg.sv
// Shared constants, types and mod-26 helpers for the Enigma rotor stage.
package enigma_pkg;

    localparam int unsigned ALPHA    = 26;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned TABLE_W  = ALPHA * IDX_W;
    localparam logic [7:0]  ASCII_UA = 8'h41;
    localparam logic [7:0]  ASCII_LA = 8'h61;

    typedef logic [IDX_W-1:0]   letter_idx_t;
    typedef logic [TABLE_W-1:0] wiring_t;

    // Operands are expected in 0..25; the sum stays within 6 bits.
    function automatic letter_idx_t mod26_add(input letter_idx_t a, input letter_idx_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 6'd26) begin
            s = s - 6'd26;
        end
        return s[IDX_W-1:0];
    endfunction

    // Bias by 26 before subtracting so the result never goes negative.
    function automatic letter_idx_t mod26_sub(input letter_idx_t a, input letter_idx_t b);
        logic [5:0] s;
        s = {1'b0, a} + 6'd26 - {1'b0, b};
        if (s >= 6'd26) begin
            s = s - 6'd26;
        end
        return s[IDX_W-1:0];
    endfunction

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UA) && (c <= 8'h5a);
    endfunction

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= 8'h7a);
    endfunction

    // Non-letters map to 0; callers gate on is_upper/is_lower.
    function automatic letter_idx_t char_to_idx(input logic [7:0] c);
        logic [7:0] d;
        d = 8'h00;
        if (is_upper(c)) begin
            d = c - ASCII_UA;
        end else if (is_lower(c)) begin
            d = c - ASCII_LA;
        end
        return d[IDX_W-1:0];
    endfunction

    function automatic logic [7:0] idx_to_char(input letter_idx_t idx, input logic lower);
        return (lower ? ASCII_LA : ASCII_UA) + {3'b000, idx};
    endfunction

    // Packs a 26-letter wiring string; leftmost letter becomes entry 0 in the LSBs.
    function automatic wiring_t pack_wiring(input logic [8*ALPHA-1:0] s);
        wiring_t    t;
        logic [7:0] c;
        logic [7:0] d;
        t = '0;
        for (int i = 0; i < ALPHA; i++) begin
            c = s[8*(ALPHA-1-i) +: 8];
            d = c - ASCII_UA;
            t[IDX_W*i +: IDX_W] = d[IDX_W-1:0];
        end
        return t;
    endfunction

    function automatic logic is_perm(input wiring_t t);
        logic [ALPHA-1:0] seen;
        logic             ok;
        letter_idx_t      e;
        seen = '0;
        ok   = 1'b1;
        for (int i = 0; i < ALPHA; i++) begin
            e = t[IDX_W*i +: IDX_W];
            if (e >= letter_idx_t'(ALPHA)) begin
                ok = 1'b0;
            end else begin
                seen[e] = 1'b1;
            end
        end
        return ok && (&seen);
    endfunction

    function automatic wiring_t invert_wiring(input wiring_t t);
        wiring_t     inv;
        letter_idx_t e;
        inv = '0;
        for (int i = 0; i < ALPHA; i++) begin
            e = t[IDX_W*i +: IDX_W];
            if (e < letter_idx_t'(ALPHA)) begin
                inv[IDX_W*e +: IDX_W] = letter_idx_t'(i);
            end
        end
        return inv;
    endfunction

    localparam wiring_t DEFAULT_WIRING = pack_wiring("AJDKSIRUXBLHWTMCQGZNPYFVOE");

endpackage

// File: rtl/enigma_rotor_stage_if.sv
// Character, stepping and status signals of one rotor stage.
interface enigma_rotor_stage_if;
    import enigma_pkg::*;

    logic        step_in;
    logic        load;
    logic [4:0]  load_pos;
    logic        in_valid;
    logic [7:0]  in_char;
    logic        dir;
    logic        out_valid;
    logic [7:0]  out_char;
    logic        carry_out;
    letter_idx_t position;

    modport master (
        output step_in, load, load_pos, in_valid, in_char, dir,
        input  out_valid, out_char, carry_out, position
    );

    modport slave (
        input  step_in, load, load_pos, in_valid, in_char, dir,
        output out_valid, out_char, carry_out, position
    );

endinterface

// File: rtl/enigma_rotor_stage_rotor_map.sv
// Combinational wheel map: offset by position and ring, substitute, undo offset.
module rotor_map
    import enigma_pkg::*;
#(
    parameter letter_idx_t RING  = '0,
    parameter wiring_t     TABLE = DEFAULT_WIRING
) (
    input  letter_idx_t idx,
    input  letter_idx_t pos,
    output letter_idx_t result
);

    letter_idx_t tbl [ALPHA];
    letter_idx_t contact;
    letter_idx_t wired;

    for (genvar g = 0; g < ALPHA; g++) begin : g_tbl
        assign tbl[g] = TABLE[g*IDX_W +: IDX_W];
    end

    // Entry contact, wire lookup, then exit contact back in the fixed frame.
    always_comb begin
        contact = mod26_sub(mod26_add(idx, pos), RING);
        wired   = tbl[contact];
        result  = mod26_add(mod26_sub(wired, pos), RING);
    end

endmodule

// File: rtl/enigma_rotor_stage.sv
// One Enigma wheel: position register, ring offset, notch carry, registered output.
// Optional reverse path selected by dir when ENIGMA_ROTOR_REVERSE_EN is defined.
module enigma_rotor_stage
    import enigma_pkg::*;
#(
    parameter wiring_t     WIRING = DEFAULT_WIRING,
    parameter int unsigned NOTCH  = 4,
    parameter int unsigned RING   = 0
) (
    input logic                 signal,
    input logic                 rst,
    enigma_rotor_stage_if.slave bus
);

    localparam letter_idx_t NOTCH_IDX = letter_idx_t'(NOTCH);
    localparam letter_idx_t RING_IDX  = letter_idx_t'(RING);

    if (!is_perm(WIRING)) begin : g_bad_wiring
        $error("enigma_rotor_stage: WIRING is not a permutation of 0..25");
    end
    if (NOTCH >= ALPHA || RING >= ALPHA) begin : g_bad_param
        $error("enigma_rotor_stage: NOTCH and RING must be in 0..25");
    end

    letter_idx_t pos_q, pos_d;
    logic        carry_q, carry_d;
    logic        out_valid_q;
    logic [7:0]  out_char_q, out_char_d;

    letter_idx_t load_red;
    letter_idx_t pos_inc;
    letter_idx_t in_idx;
    logic        in_upper;
    logic        in_lower;
    letter_idx_t fwd_idx;
    letter_idx_t map_idx;

    // Next position: load beats step; load_pos of 26..31 folds back into range.
    always_comb begin
        load_red = (bus.load_pos >= 5'd26) ? bus.load_pos - 5'd26 : bus.load_pos;
        pos_inc  = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;
        pos_d    = pos_q;
        if (bus.load) begin
            pos_d = load_red;
        end else if (bus.step_in) begin
            pos_d = pos_inc;
        end
        carry_d = bus.step_in && !bus.load && (pos_q == NOTCH_IDX);
    end

    assign in_upper = is_upper(bus.in_char);
    assign in_lower = is_lower(bus.in_char);
    assign in_idx   = char_to_idx(bus.in_char);

    // Encoding uses pos_d so a same-cycle step applies before the character.
    rotor_map #(
        .RING  (RING_IDX),
        .TABLE (WIRING)
    ) u_fwd (
        .idx    (in_idx),
        .pos    (pos_d),
        .result (fwd_idx)
    );

`ifdef ENIGMA_ROTOR_REVERSE_EN
    letter_idx_t rev_idx;

    rotor_map #(
        .RING  (RING_IDX),
        .TABLE (invert_wiring(WIRING))
    ) u_rev (
        .idx    (in_idx),
        .pos    (pos_d),
        .result (rev_idx)
    );

    assign map_idx = bus.dir ? rev_idx : fwd_idx;
`else
    logic unused_dir;

    assign unused_dir = bus.dir;
    assign map_idx    = fwd_idx;
`endif

    // Letters are substituted with case preserved; everything else passes through.
    always_comb begin
        out_char_d = out_char_q;
        if (bus.in_valid) begin
            if (in_upper || in_lower) begin
                out_char_d = idx_to_char(map_idx, in_lower);
            end else begin
                out_char_d = bus.in_char;
            end
        end
    end

    // State and output registers; reset discards any character sampled with it.
    always_ff @(posedge signal) begin
        if (rst) begin
            pos_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
        end else begin
            pos_q       <= pos_d;
            carry_q     <= carry_d;
            out_valid_q <= bus.in_valid;
            out_char_q  <= out_char_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_char  = out_char_q;
    assign bus.carry_out = carry_q;
    assign bus.position  = pos_q;

endmodule
